// File: rtl/branch_pkg.sv
// branch_pkg -- definitions shared by the branch resolver and its FIFO.
//
// Contents:
//   IP_W_DEFAULT  default instruction-pointer width
//   pred_entry_t  in-flight prediction record {ip, pred, target} at the default width
//   PRED_ENTRY_W  width of pred_entry_t
//   entry_w()     width of the same record for any instruction-pointer width
package branch_pkg;

  localparam int IP_W_DEFAULT = 16;

  typedef struct packed {
    logic [IP_W_DEFAULT-1:0] ip;
    logic                    pred;
    logic [IP_W_DEFAULT-1:0] target;
  } pred_entry_t;

  localparam int PRED_ENTRY_W = $bits(pred_entry_t);

  // The record holds two instruction pointers plus the taken bit.
  function automatic int entry_w(input int ip_w);
    return (2 * ip_w) + 1;
  endfunction

endpackage

// File: rtl/pred_fifo.sv
// pred_fifo -- in-order storage for predictions that are waiting to resolve.
//
// Parameters:
//   DEPTH  number of entries (power of two, >= 2)
//   WIDTH  entry width in bits
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset, overrides every other input
//   push       write push_data at the tail
//   push_data  entry to write
//   pop        retire the head entry (ignored while empty)
//   clear      discard every entry; wins over a same-cycle push or pop
//   full       all DEPTH entries occupied
//   empty      no entries
//   head       oldest entry (meaningless while empty)
//
// A push while full is only taken when the same cycle also pops, so a
// full FIFO that retires and refills in one cycle stays full.
module pred_fifo
  import branch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = PRED_ENTRY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop && !empty && !clear;
    push_ok  = push && !clear && (!full || pop_ok);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_data;
        // Power-of-two depth: the pointer wraps by natural overflow.
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// branch_resolver -- matches execute-stage branch outcomes against the
// predictions made at fetch, raises a one-cycle flush with a restart
// address on a mispredict, and drives the predictor update strobe.
//
// Optional feature: define BRANCH_PERF_CNT_EN to add the saturating
// branchCount / mispredictCount performance counters.
//
// Parameters:
//   DEPTH  in-flight prediction entries (power of two, >= 2)
//   IP_W   instruction-pointer width
// Ports:
//   CLOCK_50         clock, rising edge
//   RESET            synchronous active-high reset
//   fetchValid       fetch issued IP_f this cycle
//   IP_f             fetch instruction pointer
//   prediction       predicted taken for IP_f
//   predTarget       predicted target for IP_f
//   exValid          execute resolves one instruction this cycle
//   exIP             IP of the resolving instruction
//   exIsJump         resolving instruction is a conditional jump
//   exTaken          jump was taken
//   exTarget         actual jump target
//   wouldExecute     predictor update strobe (registered)
//   expectedIP       IP being updated (registered)
//   wasJump          updated instruction was a jump (registered)
//   didJump          updated jump was taken (registered)
//   flush            one-cycle flush pulse
//   redirectIP       fetch restart address, valid while flush=1
//   full             prediction FIFO full, fetch must stall
//   underflow        sticky: a resolve arrived with nothing in flight
//   branchCount      (BRANCH_PERF_CNT_EN) resolved jumps, saturating
//   mispredictCount  (BRANCH_PERF_CNT_EN) flushes, saturating
module branch_resolver
  import branch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IP_W  = IP_W_DEFAULT
) (
  input  logic            CLOCK_50,
  input  logic            RESET,
  input  logic            fetchValid,
  input  logic [IP_W-1:0] IP_f,
  input  logic            prediction,
  input  logic [IP_W-1:0] predTarget,
  input  logic            exValid,
  input  logic [IP_W-1:0] exIP,
  input  logic            exIsJump,
  input  logic            exTaken,
  input  logic [IP_W-1:0] exTarget,
  output logic            wouldExecute,
  output logic [IP_W-1:0] expectedIP,
  output logic            wasJump,
  output logic            didJump,
  output logic            flush,
  output logic [IP_W-1:0] redirectIP,
  output logic            full,
`ifdef BRANCH_PERF_CNT_EN
  output logic [15:0]     branchCount,
  output logic [15:0]     mispredictCount,
`endif
  output logic            underflow
);

  // Same record as pred_entry_t, sized by this instance's IP_W.
  typedef struct packed {
    logic [IP_W-1:0] ip;
    logic            pred;
    logic [IP_W-1:0] target;
  } entry_t;

  localparam int ENTRY_W = entry_w(IP_W);

  // Fetch handshake: fetchValid is the valid, !full is the ready. A fetch is
  // stored only in a cycle where valid=1 and ready=1 (or the head retires in
  // the same cycle); a fetch presented while full is dropped without effect,
  // so fetch must hold off until full falls.
  entry_t             push_entry;
  entry_t             head_entry;
  logic [ENTRY_W-1:0] head_bits;
  logic               fifo_full;
  logic               fifo_empty;
  logic               resolve;
  logic               dir_wrong;
  logic               ip_wrong;
  logic               mispredict;
  logic [IP_W-1:0]    redirect_calc;

  logic               flush_q, flush_d;
  logic [IP_W-1:0]    redirect_ip_q, redirect_ip_d;
  logic               would_execute_q, would_execute_d;
  logic [IP_W-1:0]    expected_ip_q, expected_ip_d;
  logic               was_jump_q, was_jump_d;
  logic               did_jump_q, did_jump_d;
  logic               underflow_q, underflow_d;

  assign push_entry = '{ip: IP_f, pred: prediction, target: predTarget};
  assign head_entry = entry_t'(head_bits);

  pred_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_pred_fifo (
    .clk       (CLOCK_50),
    .rst       (RESET),
    .push      (fetchValid),
    .push_data (push_entry),
    .pop       (exValid),
    .clear     (mispredict),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head_bits)
  );

  // Mispredict detection against the oldest in-flight prediction. A
  // non-jump predicted taken is a mispredict; so is any head whose IP does
  // not match the resolving instruction (fetch went down a wrong path).
  always_comb begin
    resolve = exValid && !fifo_empty;
    if (exIsJump) begin
      dir_wrong = (exTaken != head_entry.pred) ||
                  (exTaken && (exTarget != head_entry.target));
    end else begin
      dir_wrong = head_entry.pred;
    end
    ip_wrong      = (exIP != head_entry.ip);
    mispredict    = resolve && (dir_wrong || ip_wrong);
    redirect_calc = (exIsJump && exTaken) ? exTarget : (exIP + IP_W'(1));
  end

  always_comb begin
    flush_d         = mispredict;
    redirect_ip_d   = mispredict ? redirect_calc : redirect_ip_q;
    would_execute_d = exValid;
    expected_ip_d   = exIP;
    was_jump_d      = exIsJump;
    did_jump_d      = exTaken && exIsJump;
    // A resolve with nothing in flight still updates the predictor.
    underflow_d     = underflow_q || (exValid && fifo_empty);
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      flush_q         <= 1'b0;
      redirect_ip_q   <= '0;
      would_execute_q <= 1'b0;
      expected_ip_q   <= '0;
      was_jump_q      <= 1'b0;
      did_jump_q      <= 1'b0;
      underflow_q     <= 1'b0;
    end else begin
      flush_q         <= flush_d;
      redirect_ip_q   <= redirect_ip_d;
      would_execute_q <= would_execute_d;
      expected_ip_q   <= expected_ip_d;
      was_jump_q      <= was_jump_d;
      did_jump_q      <= did_jump_d;
      underflow_q     <= underflow_d;
    end
  end

  assign flush        = flush_q;
  assign redirectIP   = redirect_ip_q;
  assign wouldExecute = would_execute_q;
  assign expectedIP   = expected_ip_q;
  assign wasJump      = was_jump_q;
  assign didJump      = did_jump_q;
  assign underflow    = underflow_q;
  assign full         = fifo_full;

`ifdef BRANCH_PERF_CNT_EN
  logic [15:0] branch_count_q, branch_count_d;
  logic [15:0] mispredict_count_q, mispredict_count_d;

  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (resolve && exIsJump && (branch_count_q != 16'hFFFF)) begin
      branch_count_d = branch_count_q + 16'd1;
    end
    if (mispredict && (mispredict_count_q != 16'hFFFF)) begin
      mispredict_count_d = mispredict_count_q + 16'd1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branchCount     = branch_count_q;
  assign mispredictCount = mispredict_count_q;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver -- directed and randomized bench for branch_resolver.
// The reference keeps the in-flight predictions as a plain queue and applies
// the resolve/flush/update rules to it once per clock.
module tb_branch_resolver;

  localparam int DEPTH = 4;
  localparam int IP_W  = 16;
  localparam int EW    = 2 * IP_W + 1;

  // ---------------- clock / reset ----------------
  logic CLOCK_50;
  logic RESET;
  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  logic            fetchValid;
  logic [IP_W-1:0] IP_f;
  logic            prediction;
  logic [IP_W-1:0] predTarget;
  logic            exValid;
  logic [IP_W-1:0] exIP;
  logic            exIsJump;
  logic            exTaken;
  logic [IP_W-1:0] exTarget;
  logic            wouldExecute;
  logic [IP_W-1:0] expectedIP;
  logic            wasJump;
  logic            didJump;
  logic            flush;
  logic [IP_W-1:0] redirectIP;
  logic            full;
  logic            underflow;
`ifdef BRANCH_PERF_CNT_EN
  logic [15:0]     branchCount;
  logic [15:0]     mispredictCount;
`endif

  branch_resolver #(
    .DEPTH (DEPTH),
    .IP_W  (IP_W)
  ) dut (
    .CLOCK_50        (CLOCK_50),
    .RESET           (RESET),
    .fetchValid      (fetchValid),
    .IP_f            (IP_f),
    .prediction      (prediction),
    .predTarget      (predTarget),
    .exValid         (exValid),
    .exIP            (exIP),
    .exIsJump        (exIsJump),
    .exTaken         (exTaken),
    .exTarget        (exTarget),
    .wouldExecute    (wouldExecute),
    .expectedIP      (expectedIP),
    .wasJump         (wasJump),
    .didJump         (didJump),
    .flush           (flush),
    .redirectIP      (redirectIP),
    .full            (full),
`ifdef BRANCH_PERF_CNT_EN
    .branchCount     (branchCount),
    .mispredictCount (mispredictCount),
`endif
    .underflow       (underflow)
  );

  // ---------------- scoreboard / reference ----------------
  logic [EW-1:0]   exp_q[$];
  logic            m_flush;
  logic [IP_W-1:0] m_redirect;
  logic            m_we;
  logic [IP_W-1:0] m_eip;
  logic            m_wj;
  logic            m_dj;
  logic            m_underflow;
  int              checks;
  int              passes;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance the reference by one clock using the inputs currently driven,
  // let the DUT take the same edge, then compare.
  task automatic cycle();
    logic [EW-1:0]   h;
    logic [IP_W-1:0] h_ip;
    logic            h_pred;
    logic [IP_W-1:0] h_tgt;
    logic            mis;
    logic            popped;
    logic            was_full;
    if (RESET) begin
      exp_q.delete();
      m_flush     = 1'b0;
      m_redirect  = '0;
      m_we        = 1'b0;
      m_eip       = '0;
      m_wj        = 1'b0;
      m_dj        = 1'b0;
      m_underflow = 1'b0;
    end else begin
      was_full = (exp_q.size() == DEPTH);
      mis      = 1'b0;
      popped   = 1'b0;
      if (exValid) begin
        if (exp_q.size() == 0) begin
          m_underflow = 1'b1;
        end else begin
          h      = exp_q.pop_front();
          popped = 1'b1;
          h_ip   = h[EW-1 -: IP_W];
          h_pred = h[IP_W];
          h_tgt  = h[IP_W-1:0];
          if (exIP != h_ip) mis = 1'b1;
          else if (exIsJump) mis = (exTaken != h_pred) || (exTaken && (exTarget != h_tgt));
          else mis = h_pred;
        end
      end
      m_flush = mis;
      if (mis) begin
        exp_q.delete();
        if (exIsJump && exTaken) m_redirect = exTarget;
        else m_redirect = exIP + 1'b1;
      end else if (fetchValid && (!was_full || popped)) begin
        exp_q.push_back({IP_f, prediction, predTarget});
      end
      m_we = exValid;
      m_eip = exIP;
      m_wj = exIsJump;
      m_dj = exTaken && exIsJump;
    end
    @(posedge CLOCK_50);
    #1;
    check("flush", 32'(flush), 32'(m_flush));
    if (m_flush) check("redirectIP", 32'(redirectIP), 32'(m_redirect));
    check("wouldExecute", 32'(wouldExecute), 32'(m_we));
    check("expectedIP", 32'(expectedIP), 32'(m_eip));
    check("wasJump", 32'(wasJump), 32'(m_wj));
    check("didJump", 32'(didJump), 32'(m_dj));
    check("full", 32'(full), 32'(exp_q.size() == DEPTH));
    check("underflow", 32'(underflow), 32'(m_underflow));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    RESET      = 1'b0;
    fetchValid = 1'b0;
    IP_f       = '0;
    prediction = 1'b0;
    predTarget = '0;
    exValid    = 1'b0;
    exIP       = '0;
    exIsJump   = 1'b0;
    exTaken    = 1'b0;
    exTarget   = '0;
  endtask

  task automatic fetch(input logic [IP_W-1:0] ip, input logic p, input logic [IP_W-1:0] t);
    idle();
    fetchValid = 1'b1;
    IP_f       = ip;
    prediction = p;
    predTarget = t;
    cycle();
  endtask

  task automatic resolve(input logic [IP_W-1:0] ip, input logic j, input logic tk,
                         input logic [IP_W-1:0] t);
    idle();
    exValid  = 1'b1;
    exIP     = ip;
    exIsJump = j;
    exTaken  = tk;
    exTarget = t;
    cycle();
  endtask

  task automatic do_reset(input int n);
    idle();
    RESET = 1'b1;
    for (int i = 0; i < n; i++) cycle();
    RESET = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [EW-1:0] h;
    checks = 0;
    passes = 0;
    idle();
    do_reset(2);

    // correctly predicted not-taken jump
    fetch(16'h0010, 1'b0, 16'h0000);
    resolve(16'h0010, 1'b1, 1'b0, 16'h0000);
    idle(); cycle();

    // predicted not-taken, actually taken
    fetch(16'h0020, 1'b0, 16'h0000);
    resolve(16'h0020, 1'b1, 1'b1, 16'h0100);
    idle(); cycle();

    // non-jump predicted taken, including IP wrap
    fetch(16'h0030, 1'b1, 16'h0200);
    resolve(16'h0030, 1'b0, 1'b0, 16'h0000);
    fetch(16'hFFFF, 1'b1, 16'h0200);
    resolve(16'hFFFF, 1'b0, 1'b0, 16'h0000);
    idle(); cycle();

    // fill past capacity, then push+pop at full, then drain in order
    for (int i = 0; i < 5; i++) fetch(16'h0040 + 16'(i), 1'b0, 16'h0000);
    idle();
    fetchValid = 1'b1; IP_f = 16'h0050;
    exValid = 1'b1; exIP = 16'h0040;
    cycle();
    resolve(16'h0041, 1'b0, 1'b0, 16'h0000);
    resolve(16'h0042, 1'b0, 1'b0, 16'h0000);
    resolve(16'h0043, 1'b0, 1'b0, 16'h0000);
    resolve(16'h0050, 1'b0, 1'b0, 16'h0000);

    // underflow is sticky
    resolve(16'h0060, 1'b1, 1'b1, 16'h0123);
    idle(); cycle(); cycle();

    // reset with three entries in flight
    fetch(16'h0070, 1'b0, 16'h0000);
    fetch(16'h0071, 1'b0, 16'h0000);
    fetch(16'h0072, 1'b0, 16'h0000);
    do_reset(1);
    fetch(16'h0080, 1'b0, 16'h0000);
    resolve(16'h0080, 1'b0, 1'b0, 16'h0000);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      idle();
      RESET      = ($urandom_range(0, 99) < 2);
      fetchValid = ($urandom_range(0, 99) < 60);
      IP_f       = IP_W'($urandom);
      prediction = 1'($urandom_range(0, 1));
      predTarget = IP_W'($urandom);
      exValid    = ($urandom_range(0, 99) < 50);
      exIsJump   = 1'($urandom_range(0, 1));
      exIP       = IP_W'($urandom);
      exTaken    = 1'($urandom_range(0, 1));
      exTarget   = IP_W'($urandom);
      if (exp_q.size() > 0 && $urandom_range(0, 99) < 85) begin
        h    = exp_q[0];
        exIP = h[EW-1 -: IP_W];
        if ($urandom_range(0, 99) < 75) exTaken = h[IP_W];
        if ($urandom_range(0, 99) < 80) exTarget = h[IP_W-1:0];
      end
      cycle();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 Parameter DEPTH, default 4: in-flight prediction FIFO entries (power of two, >=2).
REQ-002 Parameter IP_W, default 16: instruction-pointer width.
REQ-003 CLOCK_50  in  1  sole clock, all state updates on rising edge.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 fetchValid  in  1  fetch issued instruction at IP_f this cycle.
REQ-006 IP_f  in  IP_W  fetch instruction pointer.
REQ-007 prediction  in  1  predictor taken/not-taken for IP_f.
REQ-008 predTarget  in  IP_W  predicted target for IP_f if taken.
REQ-009 exValid  in  1  execute stage resolving one instruction this cycle.
REQ-010 exIP  in  IP_W  IP of resolving instruction.
REQ-011 exIsJump  in  1  resolving instruction is a conditional jump.
REQ-012 exTaken  in  1  jump actually taken.
REQ-013 exTarget  in  IP_W  actual jump target.
REQ-014 wouldExecute  out  1  predictor update strobe.
REQ-015 expectedIP  out  IP_W  IP whose predictor state is updated.
REQ-016 wasJump  out  1  updated instruction was a jump.
REQ-017 didJump  out  1  jump outcome for update.
REQ-018 flush  out  1  one-cycle pipeline flush pulse.
REQ-019 redirectIP  out  IP_W  fetch restart address, valid while flush=1.
REQ-020 full  out  1  FIFO full; fetch shall stall.
REQ-021 underflow  out  1  sticky error: exValid with empty FIFO.

Function
REQ-022 Push {IP_f, prediction, predTarget} when fetchValid=1 and full=0; fetchValid while full SHALL be dropped, no state change.
REQ-023 Pop head when exValid=1 and FIFO non-empty; push and pop in the same cycle SHALL both occur, occupancy unchanged.
REQ-024 Mispredict = exIsJump ? (exTaken!=head.pred) or (exTaken and exTarget!=head.target) : head.pred; also mispredict when exIP!=head.IP.
REQ-025 On mispredict: next cycle flush=1, redirectIP = (exIsJump and exTaken) ? exTarget : exIP+1 (mod 2^IP_W), FIFO cleared.
REQ-026 Flush clear SHALL take priority over a same-cycle push; that push is discarded.
REQ-027 Predictor update outputs registered, latency 1: wouldExecute<=exValid, expectedIP<=exIP, wasJump<=exIsJump, didJump<=exTaken&exIsJump; wouldExecute=0 when exValid=0.
REQ-028 exValid with empty FIFO SHALL set underflow, assert no flush, still drive update outputs.
REQ-029 Pointers wrap modulo DEPTH; full = count==DEPTH, count width log2(DEPTH)+1.

Reset
REQ-030 RESET=1 SHALL clear FIFO, pointers, count; flush, wouldExecute, wasJump, didJump, underflow=0; expectedIP, redirectIP=0.
REQ-031 Reset mid-operation discards all in-flight entries; RESET overrides push, pop and flush in the same cycle.

Configuration
REQ-032 Macro BRANCH_PERF_CNT_EN defined: add outputs branchCount and mispredictCount (16 bits each, saturating, zero on reset), incremented per resolved jump / per flush.
REQ-033 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-034 Shared package branch_pkg SHALL hold IP_W default, prediction-entry record {ip, pred, target} and its width constant.
REQ-035 FIFO storage/pointers SHALL be a sub-module pred_fifo (push, pop, clear, full, empty, head); mispredict compare and redirect logic stay in branch_resolver.

Verification
REQ-036 Push IP 0x0010 pred=0; resolve exIP=0x0010 exIsJump=1 exTaken=0 -> no flush; next cycle wouldExecute=1, expectedIP=0x0010, wasJump=1, didJump=0.
REQ-037 Push 0x0020 pred=0; resolve taken, exTarget=0x0100 -> flush=1 one cycle, redirectIP=0x0100, full=0, count=0.
REQ-038 Push 0x0030 pred=1 target 0x0200; resolve exIsJump=0 -> flush, redirectIP=0x0031; exIP=0xFFFF same case -> redirectIP=0x0000.
REQ-039 Push 5 entries with DEPTH=4 -> full=1 after 4th, 5th dropped; simultaneous push+pop at full keeps full=1, order preserved.
REQ-040 exValid on empty FIFO -> underflow=1 and stays 1 until RESET; RESET mid-stream with 3 entries -> all outputs 0 next cycle, later pushes start at empty.
